// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry ID/EX register in front of the ALU.
// Resolves RAW hazards by forwarding from EX and WB, selects the A/B
// operands, stalls decode on load-use hazards, honours branch flushes and
// keeps a saturating count of load-use stall cycles.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  // Upstream handshake
  input  logic             in_valid,
  output logic             in_ready,

  // Decoded instruction fields
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_a_sel,
  input  logic             in_b_sel,
  input  logic [SEL_W-1:0] in_alu_sel,
  input  logic             in_reg_wen,

  // Forwarding sources
  input  logic             ex_wen,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             wb_wen,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,

  // Branch-resolution kill
  input  logic             flush,

  // Downstream handshake
  output logic             out_valid,
  input  logic             out_ready,

  // Registered outputs
  output logic [XLEN-1:0]  out_a_val,
  output logic [XLEN-1:0]  out_b_val,
  output logic [SEL_W-1:0] out_alu_sel,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd_addr,
  output logic             out_reg_wen,

  output logic [31:0]      stall_count
);

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ---------------------------------------------------------------------
  // Forwarding network: index 0 is rs1, index 1 is rs2.
  // ---------------------------------------------------------------------
  logic [1:0][4:0]      src_addr;
  logic [1:0][XLEN-1:0] src_data;
  logic [1:0][XLEN-1:0] fwd_val;
  logic [1:0]           ex_hit;
  logic [1:0]           wb_hit;

  assign src_addr[0] = in_rs1_addr;
  assign src_addr[1] = in_rs2_addr;
  assign src_data[0] = in_rs1_data;
  assign src_data[1] = in_rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // A load's EX result is an address, not the loaded value, so loads
      // never forward from EX; they are handled by the load-use stall.
      assign ex_hit[gi] = ex_wen && !ex_is_load && (ex_rd == src_addr[gi]);
      assign wb_hit[gi] = wb_wen && (wb_rd == src_addr[gi]);
      // x0 reads as zero, which also means a source writing rd=0 never
      // forwards (the address compare can only match a zero source here).
      assign fwd_val[gi] = (src_addr[gi] == REG_ZERO) ? '0 :
                           ex_hit[gi]                 ? ex_result :
                           wb_hit[gi]                 ? wb_data :
                                                        src_data[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Operand mux, hazard detection and handshake.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] a_mux;
  logic [XLEN-1:0] b_mux;
  logic            hazard;
  logic            capture;
  logic            drain;

  assign a_mux = in_a_sel ? in_pc  : fwd_val[0];
  assign b_mux = in_b_sel ? in_imm : fwd_val[1];

  // rs2 is always checked because store data needs rs2 even when B = imm;
  // rs1 only matters when A actually reads the register.
  assign hazard = in_valid && ex_wen && ex_is_load && (ex_rd != REG_ZERO) &&
                  (((ex_rd == in_rs1_addr) && !in_a_sel) ||
                   (ex_rd == in_rs2_addr));

  logic out_valid_reg;
  logic out_valid_next;

  assign in_ready = (!out_valid_reg || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;
  assign drain    = out_valid_reg && out_ready;

  // ---------------------------------------------------------------------
  // Registered entry.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0]  a_val_reg,   a_val_next;
  logic [XLEN-1:0]  b_val_reg,   b_val_next;
  logic [SEL_W-1:0] alu_sel_reg, alu_sel_next;
  logic [XLEN-1:0]  rs2_val_reg, rs2_val_next;
  logic [XLEN-1:0]  pc_reg,      pc_next;
  logic [4:0]       rd_addr_reg, rd_addr_next;
  logic             reg_wen_reg, reg_wen_next;
  logic [31:0]      stall_count_reg, stall_count_next;

  // Next-state: valid tracks EMPTY/FULL, data loads only on capture.
  always_comb begin
    out_valid_next   = out_valid_reg;
    a_val_next       = a_val_reg;
    b_val_next       = b_val_reg;
    alu_sel_next     = alu_sel_reg;
    rs2_val_next     = rs2_val_reg;
    pc_next          = pc_reg;
    rd_addr_next     = rd_addr_reg;
    reg_wen_next     = reg_wen_reg;
    stall_count_next = stall_count_reg;

    if (flush) begin
      out_valid_next = 1'b0;
    end else if (capture) begin
      out_valid_next = 1'b1;
    end else if (drain) begin
      out_valid_next = 1'b0;
    end

    // capture already excludes flush through in_ready
    if (capture) begin
      a_val_next   = a_mux;
      b_val_next   = b_mux;
      alu_sel_next = in_alu_sel;
      rs2_val_next = fwd_val[1];
      pc_next      = in_pc;
      rd_addr_next = in_rd_addr;
      reg_wen_next = in_reg_wen;
    end

    if (hazard && !flush && (stall_count_reg != 32'hFFFF_FFFF)) begin
      stall_count_next = stall_count_reg + 32'd1;
    end
  end

  // State registers with asynchronous clear of the held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      a_val_reg       <= '0;
      b_val_reg       <= '0;
      alu_sel_reg     <= '0;
      rs2_val_reg     <= '0;
      pc_reg          <= '0;
      rd_addr_reg     <= '0;
      reg_wen_reg     <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      out_valid_reg   <= out_valid_next;
      a_val_reg       <= a_val_next;
      b_val_reg       <= b_val_next;
      alu_sel_reg     <= alu_sel_next;
      rs2_val_reg     <= rs2_val_next;
      pc_reg          <= pc_next;
      rd_addr_reg     <= rd_addr_next;
      reg_wen_reg     <= reg_wen_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_a_val   = a_val_reg;
  assign out_b_val   = b_val_reg;
  assign out_alu_sel = alu_sel_reg;
  assign out_rs2_val = rs2_val_reg;
  assign out_pc      = pc_reg;
  assign out_rd_addr = rd_addr_reg;
  assign out_reg_wen = reg_wen_reg;
  assign stall_count = stall_count_reg;

endmodule
